// File: rtl/shift_pkg.sv
// Shared types for the shift engine: mode and state encodings,
// plus the shift-amount width helper.
package shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'd0,
        MODE_SHL   = 3'd1,
        MODE_SHR   = 3'd2,
        MODE_LOAD  = 3'd3,
        MODE_ROL   = 3'd4,
        MODE_ROR   = 3'd5,
        MODE_ASR   = 3'd6,
        MODE_CLEAR = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

    function automatic logic is_step(input mode_e m);
        return m inside {MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR};
    endfunction

endpackage

// File: rtl/shift_engine_if.sv
// Command handshake bundle for the shift engine.
// The master issues commands; the engine is the slave.
interface shift_engine_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = shift_pkg::cnt_w(WIDTH)
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_mode;
    logic [CNT_W-1:0] cmd_amount;
    logic [WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_mode,
        output cmd_amount,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_mode,
        input  cmd_amount,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/shift_step.sv
// One-step next-value function of the shift register.
// out_bit is meaningful only for the shift/rotate modes and CLEAR.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  mode_e            mode_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             ser_in_i,
    output logic [WIDTH-1:0] q_next_o,
    output logic             out_bit_o
);

    always_comb begin
        q_next_o  = q_i;
        out_bit_o = 1'b0;
        unique case (mode_i)
            MODE_SHL: begin
                q_next_o  = {q_i[WIDTH-2:0], ser_in_i};
                out_bit_o = q_i[WIDTH-1];
            end
            MODE_SHR: begin
                q_next_o  = {ser_in_i, q_i[WIDTH-1:1]};
                out_bit_o = q_i[0];
            end
            MODE_ROL: begin
                q_next_o  = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
                out_bit_o = q_i[WIDTH-1];
            end
            MODE_ROR: begin
                q_next_o  = {q_i[0], q_i[WIDTH-1:1]};
                out_bit_o = q_i[0];
            end
            MODE_ASR: begin
                q_next_o  = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
                out_bit_o = q_i[0];
            end
            MODE_CLEAR: begin
                q_next_o  = '0;
                out_bit_o = 1'b0;
            end
            MODE_HOLD, MODE_LOAD: begin
                q_next_o  = q_i;
                out_bit_o = 1'b0;
            end
            default: begin
                q_next_o  = q_i;
                out_bit_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_engine.sv
// Universal shift register executing commanded multi-step
// shift/rotate operations, one step per enabled clock.
module shift_engine
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    shift_engine_if.slave    cmd,
    input  logic             ser_in,
    input  logic             step_en,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             so_q, so_d;
    logic             done_q;

    logic [WIDTH-1:0] step_q;
    logic             step_bit;
    mode_e            cmd_mode;

    assign cmd_mode = mode_e'(cmd.cmd_mode);

    shift_step #(.WIDTH(WIDTH)) u_step (
        .mode_i    (mode_q),
        .q_i       (q_q),
        .ser_in_i  (ser_in),
        .q_next_o  (step_q),
        .out_bit_o (step_bit)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        so_d    = so_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    if (is_step(cmd_mode) && cmd.cmd_amount != '0) begin
                        mode_d  = cmd_mode;
                        cnt_d   = cmd.cmd_amount;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                        if (cmd_mode == MODE_LOAD) begin
                            q_d = cmd.cmd_data;
                        end else if (cmd_mode == MODE_CLEAR) begin
                            q_d  = '0;
                            so_d = 1'b0;
                        end
                    end
                end
            end
            ST_RUN: begin
                if (step_en) begin
                    q_d   = step_q;
                    so_d  = step_bit;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_HOLD;
            cnt_q   <= '0;
            q_q     <= '0;
            so_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            so_q    <= so_d;
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign cmd.cmd_ready = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign q             = q_q;
    assign ser_out       = so_q;
    assign done          = done_q;

endmodule

// File: tb/tb_shift_engine.sv
// Directed vector bench for shift_engine (WIDTH=8).
module tb_shift_engine;
    import shift_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       ser_in;
    logic       step_en;
    logic [7:0] q;
    logic       ser_out;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    shift_engine_if #(.WIDTH(8)) cmd_if ();

    shift_engine #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .cmd     (cmd_if.slave),
        .ser_in  (ser_in),
        .step_en (step_en),
        .q       (q),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        mode_e      mode;
        logic [3:0] amt;
        logic [7:0] data;
        logic       sin;
        logic [7:0] exp_q;
        logic       exp_so;
        int         exp_lat;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input mode_e m, input logic [3:0] amt,
                         input logic [7:0] d, input logic sin);
        int w;
        w = 0;
        while (!cmd_if.cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_cmd", int'(cmd_if.cmd_ready), 1);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_mode   = m;
        cmd_if.cmd_amount = amt;
        cmd_if.cmd_data   = d;
        ser_in            = sin;
        @(negedge clk);
        cmd_if.cmd_valid  = 1'b0;
    endtask

    task automatic wait_done(inout int lat);
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int pulses;

        vecs[0]  = '{MODE_LOAD,  4'd0,  8'hA5, 1'b0, 8'hA5, 1'b0, 1};
        vecs[1]  = '{MODE_SHL,   4'd3,  8'h00, 1'b1, 8'h2F, 1'b1, 4};
        vecs[2]  = '{MODE_LOAD,  4'd0,  8'h80, 1'b0, 8'h80, 1'b1, 1};
        vecs[3]  = '{MODE_ASR,   4'd2,  8'h00, 1'b0, 8'hE0, 1'b0, 3};
        vecs[4]  = '{MODE_LOAD,  4'd0,  8'hA5, 1'b0, 8'hA5, 1'b0, 1};
        vecs[5]  = '{MODE_ROR,   4'd4,  8'h00, 1'b0, 8'h5A, 1'b0, 5};
        vecs[6]  = '{MODE_SHL,   4'd0,  8'h00, 1'b1, 8'h5A, 1'b0, 1};
        vecs[7]  = '{MODE_LOAD,  4'd0,  8'hFF, 1'b0, 8'hFF, 1'b0, 1};
        vecs[8]  = '{MODE_ROL,   4'd1,  8'h00, 1'b0, 8'hFF, 1'b1, 2};
        vecs[9]  = '{MODE_CLEAR, 4'd5,  8'h12, 1'b1, 8'h00, 1'b0, 1};
        vecs[10] = '{MODE_HOLD,  4'd3,  8'h77, 1'b1, 8'h00, 1'b0, 1};
        vecs[11] = '{MODE_LOAD,  4'd0,  8'h3C, 1'b0, 8'h3C, 1'b0, 1};
        vecs[12] = '{MODE_SHR,   4'd9,  8'h00, 1'b1, 8'hFF, 1'b1, 10};
        vecs[13] = '{MODE_SHL,   4'd9,  8'h00, 1'b0, 8'h00, 1'b0, 10};
        vecs[14] = '{MODE_LOAD,  4'd0,  8'h81, 1'b0, 8'h81, 1'b0, 1};
        vecs[15] = '{MODE_ROL,   4'd2,  8'h00, 1'b0, 8'h06, 1'b0, 3};
        vecs[16] = '{MODE_LOAD,  4'd0,  8'h7F, 1'b0, 8'h7F, 1'b0, 1};
        vecs[17] = '{MODE_ASR,   4'd1,  8'h00, 1'b0, 8'h3F, 1'b1, 2};
        vecs[18] = '{MODE_SHR,   4'd15, 8'h00, 1'b0, 8'h00, 1'b0, 16};

        reset             = 1'b1;
        ser_in            = 1'b0;
        step_en           = 1'b1;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_mode   = 3'd0;
        cmd_if.cmd_amount = 4'd0;
        cmd_if.cmd_data   = 8'h00;

        repeat (2) @(negedge clk);
        check("rst_q", int'(q), 0);
        check("rst_ser_out", int'(ser_out), 0);
        check("rst_ready", int'(cmd_if.cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            issue(vecs[i].mode, vecs[i].amt, vecs[i].data, vecs[i].sin);
            lat = 1;
            if (vecs[i].exp_lat > 1) check($sformatf("v%0d_busy", i), int'(busy), 1);
            wait_done(lat);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_q", i), int'(q), int'(vecs[i].exp_q));
            check($sformatf("v%0d_ser_out", i), int'(ser_out), int'(vecs[i].exp_so));
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), int'(done), 0);
            check($sformatf("v%0d_ready_after", i), int'(cmd_if.cmd_ready), 1);
        end

        // ROL 4 from 0x81 with a 3-cycle stall after the first step
        issue(MODE_LOAD, 4'd0, 8'h81, 1'b0);
        lat = 1;
        wait_done(lat);
        @(negedge clk);
        issue(MODE_ROL, 4'd4, 8'h00, 1'b0);
        check("stall_accept_q", int'(q), 8'h81);
        @(negedge clk);
        check("stall_step1_q", int'(q), 8'h03);
        step_en = 1'b0;
        @(negedge clk);
        check("stall1_q", int'(q), 8'h03);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_mode   = MODE_LOAD;
        cmd_if.cmd_amount = 4'd0;
        cmd_if.cmd_data   = 8'hFF;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        check("stall2_q", int'(q), 8'h03);
        check("stall2_done", int'(done), 0);
        @(negedge clk);
        check("stall3_q", int'(q), 8'h03);
        check("stall3_busy", int'(busy), 1);
        step_en = 1'b1;
        lat = 5;
        wait_done(lat);
        check("stall_latency", lat, 8);
        check("stall_final_q", int'(q), 8'h18);
        check("stall_ser_out", int'(ser_out), 0);
        @(negedge clk);

        // Reset after the second step of SHR 6 from 0xA5
        issue(MODE_LOAD, 4'd0, 8'hA5, 1'b0);
        lat = 1;
        wait_done(lat);
        @(negedge clk);
        issue(MODE_SHR, 4'd6, 8'h00, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("abort_step2_q", int'(q), 8'hE9);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_q", int'(q), 0);
        check("abort_ser_out", int'(ser_out), 0);
        check("abort_ready", int'(cmd_if.cmd_ready), 1);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check("abort_no_done", pulses, 0);
        check("abort_idle_q", int'(q), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_engine.md
# shift_engine

Parametrised universal shift register with a command handshake. It loads, clears, holds, shifts, rotates or arithmetic-shifts a WIDTH-bit word by a commanded number of positions, one position per enabled clock. It is the general-width, multi-step successor to the team's fixed 8-bit mux/DFF shift register, and it serves datapath blocks that need serialisation or variable shifts without a barrel shifter.

## Interface
- WIDTH, 8: register width in bits, ≥2.
- CNT_W, $clog2(WIDTH)+1: width of the shift-amount field.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine idle and able to accept a command.
- cmd_mode  in  3  operation code; encodings are listed under Operation.
- cmd_amount  in  CNT_W  number of single-bit steps; used only by the shift and rotate modes.
- cmd_data  in  WIDTH  parallel load value; used only by LOAD.
- ser_in  in  1  fill bit for SHL (enters at the LSB) and SHR (enters at the MSB); sampled on every step.
- step_en  in  1  when low, the current multi-step operation stalls.
- q  out  WIDTH  register contents.
- ser_out  out  1  last bit shifted or rotated out.
- busy  out  1  a command is in progress; equals !cmd_ready.
- done  out  1  one-cycle pulse when a command completes.

## Operation
- Modes:
  - 0 HOLD: no change.
  - 1 SHL: q={q[W-2:0],ser_in}.
  - 2 SHR: q={ser_in,q[W-1:1]}.
  - 3 LOAD: q=cmd_data.
  - 4 ROL: rotate left by one.
  - 5 ROR: rotate right by one.
  - 6 ASR: q={q[W-1],q[W-1:1]}.
  - 7 CLEAR: q=0.
- ser_out per step:
  - SHL and ROL: takes the old q[W-1].
  - SHR, ROR and ASR: takes the old q[0].
  - CLEAR: drives 0.
  - HOLD and LOAD: leave ser_out unchanged.
- State machine with states IDLE, RUN and DONE.
  - IDLE: cmd_ready=1. An accept occurs when cmd_valid=1 on a rising edge.
  - On accept of HOLD, LOAD or CLEAR, or of any mode with cmd_amount=0: the operation is applied at the accept edge (HOLD and amount 0 leave q unchanged) and the next state is DONE.
  - On accept of a step mode with amount N≥1: mode and N are latched, the remaining count cnt is set to N, and the next state is RUN. q does not change at the accept edge.
  - RUN: each edge with step_en=1 performs one step and decrements cnt. On the edge where cnt goes from 1 to 0, the next state is DONE. With step_en=0, q, ser_out and cnt hold.
  - DONE: done=1 for exactly one cycle, then IDLE.
- cmd_valid, cmd_data and cmd_amount are ignored outside IDLE. ser_in is sampled live on each step, not latched at accept.
- Amounts larger than WIDTH are executed literally. For example, SHL by WIDTH+1 leaves every bit equal to ser_in.
- Reset at any time, including mid-RUN:
  - Next state is IDLE; q=0, ser_out=0, cnt=0.
  - done=0; no completion pulse is issued for the aborted command.
  - reset has priority over every other input.

## Timing
- Reset values: q=0, ser_out=0, busy=0, cmd_ready=1, done=0.
- Single-cycle ops (HOLD, LOAD, CLEAR, amount 0), accepted at edge T0: q is valid after T0, done is high in cycle T0+1, cmd_ready is high again from T0+2.
- Step op with amount N and no stalls, accepted at T0: steps occur at edges T0+1 through T0+N. done is high in cycle T0+N+1. The next accept is possible at edge T0+N+2.
- Each low cycle of step_en during RUN adds exactly one cycle to that latency.
- step_en has no effect in IDLE or DONE.
- All outputs are registered except cmd_ready and busy, which are decoded from state.

## Structure
- Shared package shift_pkg holds:
  - the mode enum (the 3-bit encodings listed under Operation);
  - the state enum (IDLE, RUN, DONE);
  - the CNT_W computation.
- Sub-module shift_step: a purely combinational one-step next-value function. Inputs are mode, q and ser_in; outputs are q_next and out_bit. The top level keeps the FSM, the counter and the registers.

## Test plan
(all with WIDTH=8)
- Reset for 2 cycles -> q=0x00, ser_out=0, cmd_ready=1, busy=0, done=0.
- LOAD cmd_data=0xA5 -> q=0xA5 after the accept edge; done pulses high for one cycle in the next cycle; cmd_ready returns 2 cycles after accept.
- From 0xA5, SHL amount 3 with ser_in=1 -> q=0x2F and ser_out=1 after 3 steps; done arrives 4 cycles after accept.
- From 0x80, ASR amount 2 -> q=0xE0. Then LOAD 0xA5 followed by ROR amount 4 -> q=0x5A. Then SHL with amount 0 -> q unchanged and done pulses.
- During ROL amount 4 from 0x81, hold step_en=0 for 3 cycles after the first step -> q frozen at 0x03 while stalled; final q=0x18; done is delayed by 3 cycles; a cmd_valid pulse during busy is ignored.
- Assert reset after the second step of SHR amount 6 -> q=0x00 on the next edge, cmd_ready=1, and no done pulse for the aborted command.
